// File: rtl/arbitrated_router_pkg.sv
// Shared NoC definitions for the arbitrated router: packet width, port count
// and the port-index encoding used on both ingress and egress.
package pa_noc;

    localparam int PACKET_WIDTH = 16;
    localparam int N_PORTS      = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } portIndex_t;

endpackage

// File: rtl/arbitrated_router_arb.sv
// rrArbiter: round-robin arbiter with one-hot grant; the priority pointer
// moves past the winner only when the grant is actually consumed.
module rrArbiter
    import pa_noc::*;
#(
    parameter int N = N_PORTS
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic [N-1:0] i_request,
    input  logic         i_enable,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] pointer;
    logic [PW-1:0] nextPointer;
    logic          anyGrant;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        o_grant     = '0;
        anyGrant    = 1'b0;
        nextPointer = pointer;
        for (int i = 0; i < N; i++) begin
            if (!anyGrant && i_request[i] && i >= int'(pointer)) begin
                anyGrant    = 1'b1;
                o_grant[i]  = 1'b1;
                nextPointer = PW'((i + 1) % N);
            end
        end
        // Wrap-around pass covers requesters below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!anyGrant && i_request[i] && i < int'(pointer)) begin
                anyGrant    = 1'b1;
                o_grant[i]  = 1'b1;
                nextPointer = PW'((i + 1) % N);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pointer <= '0;
        end else if (i_enable && anyGrant) begin
            pointer <= nextPointer;
        end
    end

endmodule

// File: rtl/arbitrated_router_fifo.sv
// synchronousFifo: single-clock FIFO with first-word-fall-through read data.
// Writes are refused when full, even if a read happens in the same cycle.
module synchronousFifo
    import pa_noc::*;
#(
    parameter int DATA_WIDTH    = PACKET_WIDTH,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDRESS_WIDTH:0] wrPtr;
    logic [ADDRESS_WIDTH:0] rdPtr;
    logic                   doWrite;
    logic                   doRead;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign o_full     = (wrPtr[ADDRESS_WIDTH] != rdPtr[ADDRESS_WIDTH]) &&
                        (wrPtr[ADDRESS_WIDTH-1:0] == rdPtr[ADDRESS_WIDTH-1:0]);
    assign o_empty    = (wrPtr == rdPtr);
    assign o_readData = mem[rdPtr[ADDRESS_WIDTH-1:0]];
    assign doWrite    = i_write && !o_full;
    assign doRead     = i_read && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (doRead)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (doWrite) mem[wrPtr[ADDRESS_WIDTH-1:0]] <= i_writeData;
    end

endmodule

// File: rtl/arbitrated_router.sv
// 5-port XY-routed mesh router with per-input FIFOs and round-robin egress.
// Define ARBITRATED_ROUTER_PERF_COUNTERS_EN to add saturating per-egress handshake counters.
module arbitrated_router
    import pa_noc::*;
#(
    parameter int GRID_WIDTH         = 4,
    parameter int GRID_HEIGHT        = 4,
    parameter int FIFO_ADDRESS_WIDTH = 2,
    parameter int ROUTER_ROW         = 0,
    parameter int ROUTER_COL         = 0
) (
    input  logic                                  i_clk,
    input  logic                                  i_arst_n,
    input  logic [N_PORTS-1:0][PACKET_WIDTH-1:0]  i_data,
    input  logic [N_PORTS-1:0]                    i_valid,
    output logic [N_PORTS-1:0]                    o_ready,
    output logic [N_PORTS-1:0][PACKET_WIDTH-1:0]  o_data,
    output logic [N_PORTS-1:0]                    o_valid,
    input  logic [N_PORTS-1:0]                    i_ready,
    output logic                                  o_routeError
`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
    ,
    output logic [N_PORTS-1:0][15:0]              o_egressCount
`endif
);

    localparam int COL_W = (GRID_WIDTH  > 1) ? $clog2(GRID_WIDTH)  : 1;
    localparam int ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;

    logic [N_PORTS-1:0][PACKET_WIDTH-1:0] headData;
    logic [N_PORTS-1:0][PACKET_WIDTH-1:0] nextData;
    logic [N_PORTS-1:0]                   fifoFull;
    logic [N_PORTS-1:0]                   fifoEmpty;
    logic [N_PORTS-1:0]                   pop;
    logic [N_PORTS-1:0]                   dropHead;
    logic [N_PORTS-1:0]                   canLoad;
    logic [N_PORTS-1:0][N_PORTS-1:0]      request;  // [egress][ingress]
    logic [N_PORTS-1:0][N_PORTS-1:0]      grant;    // [egress][ingress]

    function automatic portIndex_t xyRoute(input int destRow, input int destCol);
        if (destCol > ROUTER_COL)      return EAST;
        else if (destCol < ROUTER_COL) return WEST;
        else if (destRow > ROUTER_ROW) return SOUTH;
        else if (destRow < ROUTER_ROW) return NORTH;
        else                           return LOCAL;
    endfunction

    assign o_ready = ~fifoFull;

    for (genvar p = 0; p < N_PORTS; p++) begin : gen_ingress
        synchronousFifo #(
            .DATA_WIDTH   (PACKET_WIDTH),
            .ADDRESS_WIDTH(FIFO_ADDRESS_WIDTH)
        ) u_fifo (
            .i_clk      (i_clk),
            .i_arst_n   (i_arst_n),
            .i_write    (i_valid[p]),
            .i_writeData(i_data[p]),
            .i_read     (pop[p]),
            .o_readData (headData[p]),
            .o_full     (fifoFull[p]),
            .o_empty    (fifoEmpty[p])
        );
    end

    // Out-of-grid heads are dropped here instead of competing for an egress.
    always_comb begin
        request  = '0;
        dropHead = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!fifoEmpty[p]) begin
                if (int'(headData[p][COL_W+ROW_W-1:COL_W]) >= GRID_HEIGHT ||
                    int'(headData[p][COL_W-1:0]) >= GRID_WIDTH) begin
                    dropHead[p] = 1'b1;
                end else begin
                    request[xyRoute(int'(headData[p][COL_W+ROW_W-1:COL_W]),
                                    int'(headData[p][COL_W-1:0]))][p] = 1'b1;
                end
            end
        end
    end

    for (genvar q = 0; q < N_PORTS; q++) begin : gen_egress
        assign canLoad[q] = !o_valid[q] || i_ready[q];

        rrArbiter #(.N(N_PORTS)) u_arb (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_request(request[q]),
            .i_enable (canLoad[q]),
            .o_grant  (grant[q])
        );
    end

    always_comb begin
        pop      = dropHead;
        nextData = '0;
        for (int q = 0; q < N_PORTS; q++) begin
            if (canLoad[q]) pop = pop | grant[q];
            for (int p = 0; p < N_PORTS; p++) begin
                if (grant[q][p]) nextData[q] = nextData[q] | headData[p];
            end
        end
    end

    // Data only changes on a real load, so it holds its last value when idle.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_valid <= '0;
            o_data  <= '0;
        end else begin
            for (int q = 0; q < N_PORTS; q++) begin
                if (canLoad[q]) begin
                    o_valid[q] <= |grant[q];
                    if (|grant[q]) o_data[q] <= nextData[q];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)       o_routeError <= 1'b0;
        else if (|dropHead)  o_routeError <= 1'b1;
    end

`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_egressCount <= '0;
        end else begin
            for (int q = 0; q < N_PORTS; q++) begin
                if (o_valid[q] && i_ready[q] && o_egressCount[q] != 16'hFFFF)
                    o_egressCount[q] <= o_egressCount[q] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arbitrated_router.sv
// Directed bench for arbitrated_router: router (1,1) on a 4x4 mesh plus a 3-wide
// mesh instance for out-of-grid drops; egress outputs are checked against a scoreboard.
module tb_arbitrated_router;
    import pa_noc::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                 arstN;
    logic [N_PORTS-1:0][PACKET_WIDTH-1:0] iData, oData, iData2, oData2;
    logic [N_PORTS-1:0]                   iValid, oReady, oValid, iReady;
    logic [N_PORTS-1:0]                   iValid2, oReady2, oValid2, iReady2;
    logic                                 routeError, routeError2;
`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
    logic [N_PORTS-1:0][15:0]             egressCount, egressCount2;
`endif

    arbitrated_router #(
        .GRID_WIDTH(4), .GRID_HEIGHT(4), .FIFO_ADDRESS_WIDTH(2),
        .ROUTER_ROW(1), .ROUTER_COL(1)
    ) dut (
        .i_clk(clk), .i_arst_n(arstN),
        .i_data(iData), .i_valid(iValid), .o_ready(oReady),
        .o_data(oData), .o_valid(oValid), .i_ready(iReady),
        .o_routeError(routeError)
`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
        , .o_egressCount(egressCount)
`endif
    );

    arbitrated_router #(
        .GRID_WIDTH(3), .GRID_HEIGHT(4), .FIFO_ADDRESS_WIDTH(2),
        .ROUTER_ROW(0), .ROUTER_COL(0)
    ) dut2 (
        .i_clk(clk), .i_arst_n(arstN),
        .i_data(iData2), .i_valid(iValid2), .o_ready(oReady2),
        .o_data(oData2), .o_valid(oValid2), .i_ready(iReady2),
        .o_routeError(routeError2)
`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
        , .o_egressCount(egressCount2)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [PACKET_WIDTH-1:0]              expQ [N_PORTS][$];
    logic [PACKET_WIDTH-1:0]              expVal;
    logic                                 monEn = 1'b0;
    logic [N_PORTS-1:0]                   stalled = '0;
    logic [N_PORTS-1:0][PACKET_WIDTH-1:0] stallData;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Egress monitor: sampled mid-cycle, a valid&&ready pair is the handshake at the next edge.
    always @(negedge clk) begin
        if (!arstN) begin
            stalled = '0;
        end else if (monEn) begin
            for (int q = 0; q < N_PORTS; q++) begin
                if (stalled[q]) begin
                    check($sformatf("hold_valid_q%0d", q), 128'(oValid[q]), 128'(1'b1));
                    check($sformatf("hold_data_q%0d", q), 128'(oData[q]), 128'(stallData[q]));
                end
                if (oValid[q] && iReady[q]) begin
                    if (expQ[q].size() > 0) expVal = expQ[q].pop_front();
                    else                    expVal = 'x;
                    check($sformatf("egress_data_q%0d", q), 128'(oData[q]), 128'(expVal));
                end
                stalled[q]   = oValid[q] && !iReady[q];
                stallData[q] = oData[q];
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PACKET_WIDTH-1:0] pkt;
        iValid = '0; iData = '0; iReady = '1;
        iValid2 = '0; iData2 = '0; iReady2 = '1;
        arstN = 1'b0;
        repeat (2) tick();
        check("rst_valid", 128'(oValid), 128'(0));
        check("rst_data", 128'(oData), 128'(0));
        check("rst_ready", 128'(oReady), 128'(5'h1F));
        check("rst_error", 128'(routeError), 128'(0));
        check("rst_valid2", 128'(oValid2), 128'(0));
        check("rst_error2", 128'(routeError2), 128'(0));
        arstN = 1'b1;
        monEn = 1'b1;
        tick();
        check("post_rst_ready", 128'(oReady), 128'(5'h1F));

        // Local to (1,3): east, two cycles after drive, nothing elsewhere.
        iValid[LOCAL] = 1'b1; iData[LOCAL] = 16'hA507;
        tick();
        iValid = '0; expQ[EAST].push_back(16'hA507);
        check("east_not_yet", 128'(oValid), 128'(0));
        tick();
        check("east_valid_only", 128'(oValid), 128'(5'b01000));
        check("east_data", 128'(oData[EAST]), 128'(16'hA507));
        tick();
        check("east_idle", 128'(oValid), 128'(0));
        check("east_data_held", 128'(oData[EAST]), 128'(16'hA507));

        // North, south, west all to (1,1): local delivers N, S, W on consecutive cycles.
        iValid = 5'b10110;
        iData[NORTH] = 16'h1105; iData[SOUTH] = 16'h2205; iData[WEST] = 16'h4405;
        tick();
        iValid = '0;
        expQ[LOCAL].push_back(16'h1105);
        expQ[LOCAL].push_back(16'h2205);
        expQ[LOCAL].push_back(16'h4405);
        tick();
        check("rr_first_valid", 128'(oValid), 128'(5'b00001));
        check("rr_first_north", 128'(oData[LOCAL]), 128'(16'h1105));
        tick();
        check("rr_second_south", 128'(oData[LOCAL]), 128'(16'h2205));
        tick();
        check("rr_third_west", 128'(oData[LOCAL]), 128'(16'h4405));
        check("rr_third_valid", 128'(oValid), 128'(5'b00001));
        tick();
        check("rr_idle", 128'(oValid), 128'(0));

        // Distinct egresses serve distinct inputs in the same cycle.
        iValid = 5'b00011; iData[LOCAL] = 16'h5507; iData[NORTH] = 16'h3309;
        tick();
        iValid = '0;
        expQ[EAST].push_back(16'h5507);
        expQ[SOUTH].push_back(16'h3309);
        tick();
        check("par_valid", 128'(oValid), 128'(5'b01100));
        check("par_east", 128'(oData[EAST]), 128'(16'h5507));
        check("par_south", 128'(oData[SOUTH]), 128'(16'h3309));
        tick();

        // Backpressure: east stalled, five packets fill egress register plus FIFO.
        iReady[EAST] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ready_before_%0d", i), 128'(oReady[LOCAL]), 128'(1'b1));
            pkt = {8'hB0 + 8'(i), 8'h06};
            iValid[LOCAL] = 1'b1; iData[LOCAL] = pkt;
            tick();
            expQ[EAST].push_back(pkt);
        end
        iValid = '0;
        check("bp_ready_low", 128'(oReady[LOCAL]), 128'(1'b0));
        check("bp_east_valid", 128'(oValid[EAST]), 128'(1'b1));
        check("bp_east_head", 128'(oData[EAST]), 128'(16'hB006));
        repeat (3) tick();
        check("bp_ready_still_low", 128'(oReady[LOCAL]), 128'(1'b0));
        iReady[EAST] = 1'b1;
        repeat (7) tick();
        check("bp_all_delivered", 128'(expQ[EAST].size()), 128'(0));
        check("bp_idle", 128'(oValid), 128'(0));
        check("bp_ready_back", 128'(oReady[LOCAL]), 128'(1'b1));

        // Column 3 on a 3-wide mesh is out of grid: dropped, sticky error.
        iValid2[LOCAL] = 1'b1; iData2[LOCAL] = 16'h7703;
        tick();
        iValid2 = '0;
        check("oog_error_not_yet", 128'(routeError2), 128'(0));
        tick();
        check("oog_error_set", 128'(routeError2), 128'(1'b1));
        check("oog_no_valid", 128'(oValid2), 128'(0));
        repeat (3) tick();
        check("oog_error_sticky", 128'(routeError2), 128'(1'b1));
        check("oog_still_no_valid", 128'(oValid2), 128'(0));
        check("oog_fifo_drained", 128'(oReady2), 128'(5'h1F));
        check("main_no_error", 128'(routeError), 128'(0));

        // Reset with three packets buffered behind a stalled east egress.
        iReady[EAST] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pkt = {8'hC0 + 8'(i), 8'h06};
            iValid[LOCAL] = 1'b1; iData[LOCAL] = pkt;
            tick();
            expQ[EAST].push_back(pkt);
        end
        iValid = '0;
        check("mid_buffered_valid", 128'(oValid[EAST]), 128'(1'b1));
        arstN = 1'b0;
        for (int q = 0; q < N_PORTS; q++) expQ[q].delete();
        tick();
        check("mid_rst_valid", 128'(oValid), 128'(0));
        check("mid_rst_error2", 128'(routeError2), 128'(0));
        arstN = 1'b1;
        check("mid_rel_ready", 128'(oReady), 128'(5'h1F));
        iReady = '1;
        repeat (4) tick();
        check("mid_discarded", 128'(oValid), 128'(0));
        check("mid_rel_data", 128'(oData[EAST]), 128'(0));

        // Router still works after reset: local to (0,1) goes north.
        iValid[LOCAL] = 1'b1; iData[LOCAL] = 16'hD001;
        tick();
        iValid = '0; expQ[NORTH].push_back(16'hD001);
        tick();
        check("post_mid_north", 128'(oValid), 128'(5'b00010));
        tick();

`ifdef ARBITRATED_ROUTER_PERF_COUNTERS_EN
        begin
            int sent   = 0;
            int cycles = 0;
            logic accepted;
            check("cnt_north_one", 128'(egressCount[NORTH]), 128'(16'd1));
            check("cnt_east_zero", 128'(egressCount[EAST]), 128'(16'd0));
            iValid[LOCAL] = 1'b1;
            while (sent < 70000 && cycles < 80000) begin
                pkt = {sent[11:0], 4'h6};
                iData[LOCAL] = pkt;
                accepted = oReady[LOCAL];
                tick();
                if (accepted) begin
                    expQ[EAST].push_back(pkt);
                    sent++;
                end
                cycles++;
            end
            iValid = '0;
            check("cnt_sent_all", 128'(sent), 128'(70000));
            repeat (5) tick();
            check("cnt_east_saturated", 128'(egressCount[EAST]), 128'(16'hFFFF));
        end
`endif

        for (int q = 0; q < N_PORTS; q++)
            check($sformatf("final_empty_q%0d", q), 128'(expQ[q].size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
